// File: rtl/lag_pl_input_port_cr_pkg.sv
// lag_pl_input_port_cr_pkg: flit and FIFO-flag types plus the one-hot helper
// shared by the credit-returning router input port.
`default_nettype none

package lag_pl_input_port_cr_pkg;

  localparam int FLIT_DATA_W = 16;

  typedef struct packed {
    logic head;
    logic tail;
  } flit_ctrl_t;

  typedef struct packed {
    flit_ctrl_t               control;
    logic [FLIT_DATA_W-1:0]   data;
  } flit_t;

  typedef struct packed {
    logic empty;
    logic full;
  } fifov_flags_t;

  // True when exactly one bit is set; callers zero-extend narrower vectors.
  function automatic logic is_one_hot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lag_pl_fifo.sv
// lag_pl_fifo: single-lane first-word-fall-through FIFO with occupancy count
// and per-cycle accept/reject strobes for the enclosing input port.
`default_nettype none

module lag_pl_fifo
  import lag_pl_input_port_cr_pkg::*;
#(
  parameter int buffer_length = 8,
  parameter int cnt_w         = $clog2(buffer_length + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  flit_t              data_in,
  output flit_t              data_out,
  output logic [cnt_w-1:0]   occupancy,
  output fifov_flags_t       flags,
  output logic               pop_ok,
  output logic               push_err,
  output logic               pop_err
);

  localparam int               PTR_W    = (buffer_length > 1) ? $clog2(buffer_length) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(buffer_length - 1);
  localparam logic [cnt_w-1:0] CAPACITY = cnt_w'(buffer_length);

  flit_t             mem [buffer_length];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign flags.empty = (occupancy == '0);
  assign flags.full  = (occupancy == CAPACITY);

  // A full lane still accepts a push when a pop frees a slot on the same edge.
  assign pop_ok   = pop && !flags.empty;
  assign push_ok  = push && (!flags.full || pop_ok);
  assign push_err = push && !push_ok;
  assign pop_err  = pop && flags.empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      if (push_ok && !pop_ok)
        occupancy <= occupancy + cnt_w'(1);
      else if (pop_ok && !push_ok)
        occupancy <= occupancy - cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

  assign data_out = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/lag_pl_input_port_cr.sv
// lag_pl_input_port_cr: per-lane FWFT buffering, downstream PL tracking,
// upstream credit return and sticky protocol-error flags for a router input.
`default_nettype none

module lag_pl_input_port_cr
  import lag_pl_input_port_cr_pkg::*;
#(
  parameter int num_pls       = 4,
  parameter int buffer_length = 8,
  parameter int cnt_w         = $clog2(buffer_length + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [num_pls-1:0]                push,
  input  logic [num_pls-1:0]                pop,
  input  flit_t [num_pls-1:0]               data_in,
  output flit_t [num_pls-1:0]               data_out,
  output logic [num_pls-1:0]                empty,
  output logic [num_pls-1:0]                full,
  output logic [num_pls-1:0][cnt_w-1:0]     occupancy,
  input  logic [num_pls-1:0][num_pls-1:0]   pl_new,
  input  logic [num_pls-1:0]                pl_new_valid,
  output logic [num_pls-1:0][num_pls-1:0]   allocated_pl,
  output logic [num_pls-1:0]                allocated_pl_valid,
  output logic [num_pls-1:0]                credit_out,
  output logic                              err_overflow,
  output logic                              err_underflow,
  output logic                              err_alloc
);

  logic [num_pls-1:0] pop_ok;
  logic [num_pls-1:0] push_err;
  logic [num_pls-1:0] pop_err;
  logic [num_pls-1:0] alloc_err;

  for (genvar i = 0; i < num_pls; i++) begin : g_lane
    fifov_flags_t flags;
    logic         tail_pop;
    logic         grant_ok;

    lag_pl_fifo #(
      .buffer_length (buffer_length),
      .cnt_w         (cnt_w)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .pop       (pop[i]),
      .data_in   (data_in[i]),
      .data_out  (data_out[i]),
      .occupancy (occupancy[i]),
      .flags     (flags),
      .pop_ok    (pop_ok[i]),
      .push_err  (push_err[i]),
      .pop_err   (pop_err[i])
    );

    assign empty[i] = flags.empty;
    assign full[i]  = flags.full;

    // Releasing the PL on a tail pop outranks any grant in the same cycle,
    // so a single-flit packet never leaves a stale allocation behind.
    assign tail_pop     = pop_ok[i] && data_out[i].control.tail;
    assign grant_ok     = pl_new_valid[i] && !allocated_pl_valid[i]
                          && is_one_hot(32'(pl_new[i]));
    assign alloc_err[i] = pl_new_valid[i] && !tail_pop && !grant_ok;

    always_ff @(posedge clk) begin
      if (rst) begin
        allocated_pl[i]       <= '0;
        allocated_pl_valid[i] <= 1'b0;
      end else if (tail_pop) begin
        allocated_pl[i]       <= '0;
        allocated_pl_valid[i] <= 1'b0;
      end else if (grant_ok) begin
        allocated_pl[i]       <= pl_new[i];
        allocated_pl_valid[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_out    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_alloc     <= 1'b0;
    end else begin
      credit_out    <= pop_ok;
      err_overflow  <= err_overflow  | (|push_err);
      err_underflow <= err_underflow | (|pop_err);
      err_alloc     <= err_alloc     | (|alloc_err);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lag_pl_input_port_cr.sv
// tb_lag_pl_input_port_cr: directed scenarios with hand-computed expectations
// for the credit-returning router input port (4 lanes, 8-deep FIFOs).
`default_nettype none

module tb_lag_pl_input_port_cr;
  import lag_pl_input_port_cr_pkg::*;

  localparam int NP  = 4;
  localparam int BL  = 8;
  localparam int CW  = $clog2(BL + 1);

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NP-1:0]            push;
  logic [NP-1:0]            pop;
  flit_t [NP-1:0]           data_in;
  flit_t [NP-1:0]           data_out;
  logic [NP-1:0]            empty;
  logic [NP-1:0]            full;
  logic [NP-1:0][CW-1:0]    occupancy;
  logic [NP-1:0][NP-1:0]    pl_new;
  logic [NP-1:0]            pl_new_valid;
  logic [NP-1:0][NP-1:0]    allocated_pl;
  logic [NP-1:0]            allocated_pl_valid;
  logic [NP-1:0]            credit_out;
  logic                     err_overflow;
  logic                     err_underflow;
  logic                     err_alloc;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lag_pl_input_port_cr #(
    .num_pls       (NP),
    .buffer_length (BL)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .push               (push),
    .pop                (pop),
    .data_in            (data_in),
    .data_out           (data_out),
    .empty              (empty),
    .full               (full),
    .occupancy          (occupancy),
    .pl_new             (pl_new),
    .pl_new_valid       (pl_new_valid),
    .allocated_pl       (allocated_pl),
    .allocated_pl_valid (allocated_pl_valid),
    .credit_out         (credit_out),
    .err_overflow       (err_overflow),
    .err_underflow      (err_underflow),
    .err_alloc          (err_alloc)
  );

  function automatic flit_t mk(input logic head, input logic tail, input logic [15:0] d);
    flit_t f;
    f.control.head = head;
    f.control.tail = tail;
    f.data         = d;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push         = '0;
    pop          = '0;
    pl_new       = '0;
    pl_new_valid = '0;
    data_in      = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (occupancy !== '0) $display("FAIL reset_occ got %h want 0", occupancy); else n_pass++;
    n_total++; if (empty !== 4'hF) $display("FAIL reset_empty got %b want 1111", empty); else n_pass++;
    n_total++; if (full !== 4'h0) $display("FAIL reset_full got %b want 0000", full); else n_pass++;
    n_total++; if (allocated_pl_valid !== 4'h0) $display("FAIL reset_alloc_valid got %b want 0000", allocated_pl_valid); else n_pass++;
    n_total++; if (allocated_pl !== '0) $display("FAIL reset_alloc_pl got %h want 0", allocated_pl); else n_pass++;
    n_total++; if (credit_out !== 4'h0) $display("FAIL reset_credit got %b want 0000", credit_out); else n_pass++;
    n_total++; if ({err_overflow, err_underflow, err_alloc} !== 3'b000)
      $display("FAIL reset_errs got %b want 000", {err_overflow, err_underflow, err_alloc}); else n_pass++;
  endtask

  task automatic fill_lane0();
    for (int k = 0; k < BL; k++) begin
      push[0]    = 1'b1;
      data_in[0] = mk(1'b0, 1'b0, 16'h0100 + 16'(k));
      tick();
    end
    idle();
  endtask

  task automatic test_fill();
    do_reset();
    fill_lane0();
    n_total++; if (occupancy[0] !== CW'(8)) $display("FAIL fill_occ got %0d want 8", occupancy[0]); else n_pass++;
    n_total++; if (full[0] !== 1'b1) $display("FAIL fill_full got %b want 1", full[0]); else n_pass++;
    n_total++; if (data_out[0].data !== 16'h0100) $display("FAIL fill_head got %h want 0100", data_out[0].data); else n_pass++;
    n_total++; if (err_overflow !== 1'b0) $display("FAIL fill_no_ovf got %b want 0", err_overflow); else n_pass++;
    push[0]    = 1'b1;
    data_in[0] = mk(1'b0, 1'b0, 16'h01FF);
    tick();
    idle();
    n_total++; if (err_overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", err_overflow); else n_pass++;
    n_total++; if (occupancy[0] !== CW'(8)) $display("FAIL ovf_occ got %0d want 8", occupancy[0]); else n_pass++;
    n_total++; if (credit_out[0] !== 1'b0) $display("FAIL ovf_credit got %b want 0", credit_out[0]); else n_pass++;
  endtask

  task automatic test_push_pop_full();
    logic [15:0] exp_seq [BL];
    do_reset();
    fill_lane0();
    push[0]    = 1'b1;
    pop[0]     = 1'b1;
    data_in[0] = mk(1'b0, 1'b0, 16'h0200);
    tick();
    idle();
    n_total++; if (occupancy[0] !== CW'(8)) $display("FAIL pp_occ got %0d want 8", occupancy[0]); else n_pass++;
    n_total++; if (err_overflow !== 1'b0) $display("FAIL pp_ovf got %b want 0", err_overflow); else n_pass++;
    n_total++; if (credit_out !== 4'b0001) $display("FAIL pp_credit got %b want 0001", credit_out); else n_pass++;
    n_total++; if (data_out[0].data !== 16'h0101) $display("FAIL pp_head got %h want 0101", data_out[0].data); else n_pass++;
    tick();
    n_total++; if (credit_out !== 4'b0000) $display("FAIL pp_credit_drop got %b want 0000", credit_out); else n_pass++;
    // Drain: the write pointer has wrapped, so 0x0200 sits behind 0x0107.
    for (int k = 0; k < BL - 1; k++) exp_seq[k] = 16'h0101 + 16'(k);
    exp_seq[BL-1] = 16'h0200;
    for (int k = 0; k < BL; k++) begin
      n_total++; if (data_out[0].data !== exp_seq[k])
        $display("FAIL drain_data[%0d] got %h want %h", k, data_out[0].data, exp_seq[k]); else n_pass++;
      pop[0] = 1'b1;
      tick();
    end
    idle();
    n_total++; if (empty[0] !== 1'b1 || occupancy[0] !== '0)
      $display("FAIL drain_empty got empty=%b occ=%0d want 1/0", empty[0], occupancy[0]); else n_pass++;
    n_total++; if (err_underflow !== 1'b0) $display("FAIL drain_unf got %b want 0", err_underflow); else n_pass++;
  endtask

  task automatic test_single_flit();
    do_reset();
    push[1]    = 1'b1;
    data_in[1] = mk(1'b1, 1'b1, 16'h0A11);
    tick();
    idle();
    pl_new_valid[1] = 1'b1;
    pl_new[1]       = 4'b0100;
    pop[1]          = 1'b1;
    tick();
    idle();
    n_total++; if (allocated_pl_valid[1] !== 1'b0) $display("FAIL sf_valid got %b want 0", allocated_pl_valid[1]); else n_pass++;
    n_total++; if (allocated_pl[1] !== 4'b0000) $display("FAIL sf_pl got %b want 0000", allocated_pl[1]); else n_pass++;
    n_total++; if (credit_out !== 4'b0010) $display("FAIL sf_credit got %b want 0010", credit_out); else n_pass++;
    n_total++; if (err_alloc !== 1'b0) $display("FAIL sf_err_alloc got %b want 0", err_alloc); else n_pass++;
    tick();
    n_total++; if (credit_out !== 4'b0000) $display("FAIL sf_credit_once got %b want 0000", credit_out); else n_pass++;
  endtask

  task automatic test_multi_flit();
    logic [2:0]  exp_valid;
    int          credits;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push[2]    = 1'b1;
      data_in[2] = mk(k == 0, k == 2, 16'h0B00 + 16'(k));
      tick();
    end
    idle();
    pl_new_valid[2] = 1'b1;
    pl_new[2]       = 4'b0010;
    tick();
    idle();
    n_total++; if (allocated_pl_valid[2] !== 1'b1 || allocated_pl[2] !== 4'b0010)
      $display("FAIL mf_grant got v=%b pl=%b want 1/0010", allocated_pl_valid[2], allocated_pl[2]); else n_pass++;
    exp_valid = 3'b011;
    credits   = 0;
    for (int k = 0; k < 3; k++) begin
      pop[2] = 1'b1;
      tick();
      idle();
      if (credit_out[2] === 1'b1) credits++;
      n_total++; if (allocated_pl_valid[2] !== exp_valid[k])
        $display("FAIL mf_valid_pop%0d got %b want %b", k, allocated_pl_valid[2], exp_valid[k]); else n_pass++;
    end
    n_total++; if (credits != 3) $display("FAIL mf_credits got %0d want 3", credits); else n_pass++;
    n_total++; if (allocated_pl[2] !== 4'b0000) $display("FAIL mf_pl_clear got %b want 0000", allocated_pl[2]); else n_pass++;
    n_total++; if (empty[2] !== 1'b1) $display("FAIL mf_empty got %b want 1", empty[2]); else n_pass++;
  endtask

  task automatic test_errors();
    do_reset();
    pl_new_valid[3] = 1'b1;
    pl_new[3]       = 4'b0001;
    tick();
    idle();
    pl_new_valid[3] = 1'b1;
    pl_new[3]       = 4'b1000;
    tick();
    idle();
    n_total++; if (err_alloc !== 1'b1) $display("FAIL regrant_err got %b want 1", err_alloc); else n_pass++;
    n_total++; if (allocated_pl[3] !== 4'b0001 || allocated_pl_valid[3] !== 1'b1)
      $display("FAIL regrant_keep got pl=%b v=%b want 0001/1", allocated_pl[3], allocated_pl_valid[3]); else n_pass++;

    do_reset();
    pl_new_valid[0] = 1'b1;
    pl_new[0]       = 4'b0110;
    tick();
    idle();
    n_total++; if (err_alloc !== 1'b1) $display("FAIL multihot_err got %b want 1", err_alloc); else n_pass++;
    n_total++; if (allocated_pl_valid[0] !== 1'b0 || allocated_pl[0] !== 4'b0000)
      $display("FAIL multihot_keep got v=%b pl=%b want 0/0000", allocated_pl_valid[0], allocated_pl[0]); else n_pass++;

    pop[2] = 1'b1;
    tick();
    idle();
    n_total++; if (err_underflow !== 1'b1) $display("FAIL unf_flag got %b want 1", err_underflow); else n_pass++;
    n_total++; if (occupancy[2] !== '0) $display("FAIL unf_occ got %0d want 0", occupancy[2]); else n_pass++;
    n_total++; if (credit_out !== 4'b0000) $display("FAIL unf_credit got %b want 0000", credit_out); else n_pass++;

    push[2]    = 1'b1;
    pop[2]     = 1'b1;
    data_in[2] = mk(1'b1, 1'b0, 16'h0C33);
    tick();
    idle();
    n_total++; if (occupancy[2] !== CW'(1)) $display("FAIL unf_push_occ got %0d want 1", occupancy[2]); else n_pass++;
    n_total++; if (credit_out !== 4'b0000) $display("FAIL unf_push_credit got %b want 0000", credit_out); else n_pass++;
    n_total++; if (data_out[2].data !== 16'h0C33) $display("FAIL unf_push_data got %h want 0C33", data_out[2].data); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push       = 4'b1001;
      data_in[0] = mk(k == 0, 1'b0, 16'h0D00 + 16'(k));
      data_in[3] = mk(k == 0, 1'b0, 16'h0E00 + 16'(k));
      tick();
    end
    idle();
    pl_new_valid = 4'b1001;
    pl_new[0]    = 4'b0001;
    pl_new[3]    = 4'b1000;
    pop[1]       = 1'b1;
    tick();
    idle();
    n_total++; if (occupancy[3] !== CW'(5) || allocated_pl_valid !== 4'b1001)
      $display("FAIL mr_setup got occ3=%0d v=%b want 5/1001", occupancy[3], allocated_pl_valid); else n_pass++;
    rst    = 1'b1;
    pop[0] = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    n_total++; if (occupancy !== '0) $display("FAIL mr_occ got %h want 0", occupancy); else n_pass++;
    n_total++; if (empty !== 4'hF || full !== 4'h0)
      $display("FAIL mr_flags got empty=%b full=%b want 1111/0000", empty, full); else n_pass++;
    n_total++; if (allocated_pl_valid !== 4'h0 || allocated_pl !== '0)
      $display("FAIL mr_alloc got v=%b pl=%h want 0/0", allocated_pl_valid, allocated_pl); else n_pass++;
    n_total++; if (credit_out !== 4'h0) $display("FAIL mr_credit got %b want 0000", credit_out); else n_pass++;
    n_total++; if (err_underflow !== 1'b0) $display("FAIL mr_err got %b want 0", err_underflow); else n_pass++;
    tick();
    n_total++; if (credit_out !== 4'h0) $display("FAIL mr_credit_after got %b want 0000", credit_out); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_push_pop_full();
    test_single_flit();
    test_multi_flit();
    test_errors();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
